// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave in front of a 2^MEM_AW x 32-bit synchronous RAM.
// Independent read and write engines; every burst is treated as INCR with a
// 4-byte stride.
// Optional build macro AXI_SLV_ERR_EN: beats whose address lies above the RAM
// answer SLVERR (reads return zero, writes to those beats are dropped).
// Without it, upper address bits are ignored and the RAM aliases.
module axi_sram_slave #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  // AR channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // R channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // AW channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // W channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // B channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_RD, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [31:0] mem [2**MEM_AW];

  rstate_t     rstate_q, rstate_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [3:0]  rlen_q, rlen_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  wstate_t     wstate_q, wstate_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        werr_q, werr_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic rd_oor, wr_oor, wr_en;

`ifdef AXI_SLV_ERR_EN
  assign rd_oor = |raddr_q[31:MEM_AW+2];
  assign wr_oor = |waddr_q[31:MEM_AW+2];
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  // Handshakes and outputs; everything is forced low while reset is held.
  assign arready = !reset && (rstate_q == R_IDLE);
  assign rvalid  = !reset && (rstate_q == R_DATA);
  assign rlast   = rvalid && (rcnt_q == rlen_q);
  assign rid     = reset ? 4'd0  : rid_q;
  assign rdata   = reset ? 32'd0 : rdata_q;
  assign rresp   = reset ? 2'd0  : rresp_q;

  assign awready = !reset && (wstate_q == W_IDLE);
  assign wready  = !reset && (wstate_q == W_DATA);
  assign bvalid  = !reset && (wstate_q == W_RESP);
  assign bid     = reset ? 4'd0 : bid_q;
  assign bresp   = (reset || !werr_q) ? 2'b00 : 2'b10;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign wr_en = w_hs && !wr_oor;

  // Read engine next state: latch AR, fetch a word, present it, repeat.
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d    = arid;
          raddr_d  = araddr;
          rlen_d   = arlen[3:0];
          rcnt_d   = 4'd0;
          rstate_d = R_RD;
        end
      end
      R_RD: rstate_d = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          if (rcnt_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            raddr_d  = raddr_q + 32'd4;
            rcnt_d   = rcnt_q + 4'd1;
            rstate_d = R_RD;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read engine registers; the RAM word is captured while in R_RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      rid_q    <= 4'd0;
      raddr_q  <= 32'd0;
      rlen_q   <= 4'd0;
      rcnt_q   <= 4'd0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      if (rstate_q == R_RD) begin
        if (rd_oor) begin
          rdata_q <= 32'd0;
          rresp_q <= 2'b10;
        end else begin
          rdata_q <= mem[raddr_q[MEM_AW+1:2]];
          rresp_q <= 2'b00;
        end
      end
    end
  end

  // Write engine next state: latch AW, count awlen+1 beats, then respond.
  always_comb begin
    wstate_d = wstate_q;
    bid_d    = bid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          bid_d    = awid;
          waddr_d  = awaddr;
          wlen_d   = awlen;
          wcnt_d   = 4'd0;
          werr_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          werr_d  = werr_q | wr_oor;
          waddr_d = waddr_q + 32'd4;
          wcnt_d  = wcnt_q + 4'd1;
          if (wcnt_q == wlen_q) wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write engine registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      bid_q    <= 4'd0;
      waddr_q  <= 32'd0;
      wlen_q   <= 4'd0;
      wcnt_q   <= 4'd0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      bid_q    <= bid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
    end
  end

  // Byte-lane RAM write; no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr_q[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Sideband fields the slave deliberately ignores.
  logic unused_ok;
  assign unused_ok = ^{arsize, arburst, arlock, arcache, arprot, arlen[7:4],
                       awsize, awburst, awlock, awcache, awprot, wid, wlast,
                       raddr_q[1:0], raddr_q[31:MEM_AW+2],
                       waddr_q[1:0], waddr_q[31:MEM_AW+2]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized and directed bench for axi_sram_slave with a
// word-array reference model of the RAM.
`timescale 1ns/1ps
module tb_axi_sram_slave;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] arid;  logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0] arburst; logic [1:0] arlock; logic [3:0] arcache; logic [2:0] arprot;
  logic arvalid, arready;
  logic [3:0] rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [3:0] awid;  logic [31:0] awaddr; logic [3:0] awlen; logic [2:0] awsize;
  logic [1:0] awburst; logic [1:0] awlock; logic [3:0] awcache; logic [2:0] awprot;
  logic awvalid, awready;
  logic [3:0] wid; logic [31:0] wdata; logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0] bid; logic [1:0] bresp; logic bvalid, bready;

  axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rbeats [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
`ifdef AXI_SLV_ERR_EN
    return a[31:MEM_AW+2] != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return oor(a) ? 32'd0 : model[widx(a)];
  endfunction

  // Burst write of wd/ws[0..len]; the model is updated beat by beat.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len, input string tag);
    int beat = 0;
    int cyc = 0;
    int bwait;
    bit aw_done = 0;
    bit hs_aw, hs_w;
    bit err = 0;
    logic [31:0] a;
    awid = id; awaddr = addr; awlen = len[3:0];
    awsize = 3'($urandom); awburst = 2'($urandom); awlock = 2'($urandom);
    awcache = 4'($urandom); awprot = 3'($urandom); awvalid = 1'b1;
    wid = 4'($urandom); wdata = wd[0]; wstrb = ws[0]; wlast = 1'($urandom); wvalid = 1'b1;
    while (!aw_done || beat <= len) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (hs_w) begin
        a = addr + 32'(4 * beat);
        if (oor(a)) err = 1;
        else for (int i = 0; i < 4; i++)
          if (ws[beat][i]) model[widx(a)][8*i +: 8] = wd[beat][8*i +: 8];
      end
      @(posedge clk); #1; cyc++;
      if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
      if (hs_w) begin
        beat++;
        if (beat <= len) begin wdata = wd[beat]; wstrb = ws[beat]; wlast = 1'($urandom); end
        else wvalid = 1'b0;
      end
      if (cyc > 300) begin
        check_val({tag, "_w_timeout"}, 32'd0, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
    check_val({tag, "_wready_after_last"}, 32'(wready), 32'd0);
    bwait = $urandom_range(0, 2);
    cyc = 0;
    while (!bvalid) begin
      @(posedge clk); #1;
      if (++cyc > 20) begin check_val({tag, "_b_timeout"}, 32'd0, 32'd1); return; end
    end
    repeat (bwait) begin @(posedge clk); #1; check_val({tag, "_bvalid_hold"}, 32'(bvalid), 32'd1); end
    bready = 1'b1;
    check_val({tag, "_bid"}, 32'(bid), 32'(id));
    check_val({tag, "_bresp"}, 32'(bresp), err ? 32'd2 : 32'd0);
    @(posedge clk); #1;
    bready = 1'b0;
    check_val({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
  endtask

  // Burst read; beats land in rbeats, protocol timing is checked here.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input bit stall, input string tag);
    int nb;
    int beat = 0;
    int lat = 0;
    bit tog = 0, held = 0, gap = 0, first = 1;
    logic [31:0] hd;
    rbeats.delete();
    arid = id; araddr = addr; arlen = len;
    arsize = 3'($urandom); arburst = 2'($urandom); arlock = 2'($urandom);
    arcache = 4'($urandom); arprot = 3'($urandom); arvalid = 1'b1;
    while (!arready) begin
      @(posedge clk); #1;
      if (++lat > 100) begin check_val({tag, "_ar_timeout"}, 32'd0, 32'd1); arvalid = 1'b0; return; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 1;
    nb = int'(len[3:0]) + 1;
    while (beat < nb) begin
      if (held) begin
        check_val({tag, "_stall_valid"}, 32'(rvalid), 32'd1);
        check_val({tag, "_stall_data"}, rdata, hd);
        held = 0;
      end
      if (gap) begin check_val({tag, "_beat_gap"}, 32'(rvalid), 32'd0); gap = 0; end
      if (rvalid) begin
        if (first) begin check_val({tag, "_latency"}, 32'(lat), 32'd2); first = 0; end
        rready = !stall || tog;
        tog = !tog;
        if (rready) begin
          check_val({tag, "_rid"}, 32'(rid), 32'(id));
          check_val({tag, "_rlast"}, 32'(rlast), 32'(beat == nb - 1));
          check_val({tag, "_rresp"}, 32'(rresp), oor(addr + 32'(4 * beat)) ? 32'd2 : 32'd0);
          rbeats.push_back(rdata);
          beat++;
          gap = 1;
        end else begin
          held = 1;
          hd = rdata;
        end
      end
      @(posedge clk); #1;
      rready = 1'b0;
      if (++lat > 400) begin check_val({tag, "_r_timeout"}, 32'd0, 32'd1); return; end
    end
    check_val({tag, "_rvalid_after_last"}, 32'(rvalid), 32'd0);
  endtask

  task automatic cmp_model(input string tag, input logic [31:0] addr, input int n);
    check_val({tag, "_nbeats"}, 32'(rbeats.size()), 32'(n));
    for (int i = 0; i < n && i < rbeats.size(); i++)
      check_val({tag, "_data"}, rbeats[i], model_rd(addr + 32'(4 * i)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, cyc, len;
    bit hs_aw, hs_w;
    logic [31:0] addr;
    logic [7:0] rlen8;
    reset = 1'b1;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0; arvalid = 0;
    rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_arready", 32'(arready), 0);
    check_val("rst_awready", 32'(awready), 0);
    check_val("rst_wready", 32'(wready), 0);
    check_val("rst_rvalid", 32'(rvalid), 0);
    check_val("rst_bvalid", 32'(bvalid), 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_rid", 32'(rid), 0);
    check_val("rst_bid", 32'(bid), 0);
    check_val("rst_rresp", 32'(rresp), 0);
    check_val("rst_bresp", 32'(bresp), 0);
    check_val("rst_rlast", 32'(rlast), 0);
    reset = 1'b0;
    #1;
    check_val("post_rst_arready", 32'(arready), 1);
    check_val("post_rst_awready", 32'(awready), 1);

    // Fill the whole RAM so every later read has a defined expectation
    for (int b = 0; b < DEPTH; b += 16) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write(4'($urandom), 32'(b * 4), 15, "fill");
    end

    // Single full-word write then read back
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(4'h5, 32'h10, 0, "single_wr");
    axi_read(4'h6, 32'h10, 8'd0, 0, "single_rd");
    check_val("single_rd_nbeats", 32'(rbeats.size()), 1);
    check_val("single_rd_data", rbeats.size() > 0 ? rbeats[0] : 32'hX, 32'hDEADBEEF);

    // Partial (byte lane 1) write
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_write(4'h1, 32'h20, 0, "pre_partial");
    wd[0] = 32'h0000AA00; ws[0] = 4'b0010;
    axi_write(4'h2, 32'h20, 0, "partial_wr");
    axi_read(4'h3, 32'h20, 8'd0, 0, "partial_rd");
    check_val("partial_rd_data", rbeats.size() > 0 ? rbeats[0] : 32'hX, 32'h1122AA44);

    // Four-beat burst, read back with rready toggling
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(4'h7, 32'h100, 3, "burst_wr");
    axi_read(4'h8, 32'h100, 8'd3, 1, "burst_rd");
    check_val("burst_rd_nbeats", 32'(rbeats.size()), 4);
    for (int i = 0; i < 4 && i < rbeats.size(); i++)
      check_val("burst_rd_data", rbeats[i], 32'(i + 1));

    // AW and AR to the same word in the same cycle: read sees old data
    wd[0] = 32'h5; ws[0] = 4'hF;
    axi_write(4'h1, 32'h40, 0, "coll_pre");
    wd[0] = 32'h9;
    fork
      axi_write(4'h2, 32'h40, 0, "coll_wr");
      axi_read(4'h3, 32'h40, 8'd0, 0, "coll_rd");
    join
    check_val("coll_rd_old", rbeats.size() > 0 ? rbeats[0] : 32'hX, 32'h5);
    axi_read(4'h4, 32'h40, 8'd0, 0, "coll_rd2");
    check_val("coll_rd_new", rbeats.size() > 0 ? rbeats[0] : 32'hX, 32'h9);

    // Reset in the middle of a 4-beat write, after beat 2
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0A0_0000 + 32'(i); ws[i] = 4'hF; end
    awid = 4'h3; awaddr = 32'h200; awlen = 4'd3; awvalid = 1'b1;
    wdata = wd[0]; wstrb = 4'hF; wvalid = 1'b1;
    beat = 0; cyc = 0;
    while (beat < 2 && cyc < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (hs_w) model[widx(32'h200 + 32'(4 * beat))] = wd[beat];
      @(posedge clk); #1; cyc++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w) begin beat++; wdata = wd[beat]; end
    end
    check_val("midrst_beats_taken", 32'(beat), 2);
    reset = 1'b1;
    #1;
    check_val("midrst_wready", 32'(wready), 0);
    check_val("midrst_bvalid", 32'(bvalid), 0);
    @(posedge clk); #1;
    check_val("midrst_awready_in_rst", 32'(awready), 0);
    reset = 1'b0; wvalid = 1'b0;
    #1;
    check_val("midrst_awready_after", 32'(awready), 1);
    check_val("midrst_wready_after", 32'(wready), 0);
    repeat (3) begin @(posedge clk); #1; check_val("midrst_no_b", 32'(bvalid), 0); end
    axi_read(4'h9, 32'h200, 8'd3, 0, "midrst_rd");
    cmp_model("midrst_rd", 32'h200, 4);

    // Address above the RAM
    axi_read(4'hA, 32'h0010_0000, 8'd0, 0, "high_rd");
`ifdef AXI_SLV_ERR_EN
    check_val("high_rd_data", rbeats.size() > 0 ? rbeats[0] : 32'hX, 32'd0);
`else
    check_val("high_rd_data", rbeats.size() > 0 ? rbeats[0] : 32'hX, model[0]);
`endif

    // Randomized write/read pairs (including wrap, aliasing and ignored arlen[7:4])
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 15);
      addr = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      if ($urandom_range(0, 3) == 0) addr[31:12] = 20'($urandom);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      axi_write(4'($urandom), addr, len, "rand_wr");
      rlen8 = {4'($urandom), 4'(len)};
      axi_read(4'($urandom), addr, rlen8, 1'($urandom), "rand_rd");
      cmp_model("rand_rd", addr, len + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, giving the log2 of the RAM depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have AR ports: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-005 SHALL have R ports: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 SHALL have AW ports: awid in 4, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
REQ-007 SHALL have W ports: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-008 SHALL have B ports: bid out 4, bresp out 2, bvalid out 1, bready in 1.

Function
REQ-009 SHALL hold 2^MEM_AW x 32-bit words; word index = addr[MEM_AW+1:2].
REQ-010 SHALL ignore arsize, arburst, arlock, arcache, arprot, awsize, awburst, awlock, awcache, awprot and wid; all bursts are INCR, +4 bytes per beat, regardless of size.
REQ-011 SHALL use arlen[3:0] as the read burst length (beats = arlen[3:0]+1) and SHALL ignore arlen[7:4].
REQ-012 SHALL run the read FSM through states R_IDLE, R_RD and R_DATA.
REQ-013 SHALL assert arready=1 only in R_IDLE; on arvalid&&arready it SHALL latch arid, araddr and length, then go to R_RD.
REQ-014 In R_RD it SHALL issue a synchronous RAM read of the current word and go to R_DATA.
REQ-015 In R_DATA it SHALL drive rvalid=1, with rdata/rid/rlast held stable until rready.
REQ-016 On rvalid&&rready with the last beat, the read FSM SHALL go to R_IDLE; otherwise it SHALL increment the address and beat count and go to R_RD.
REQ-017 First rvalid SHALL occur 2 cycles after the AR handshake; sustained rate SHALL be 1 beat per 2 cycles.
REQ-018 rid SHALL equal the latched arid; rlast SHALL be 1 only on the final beat.
REQ-019 SHALL run the write FSM through states W_IDLE, W_DATA and W_RESP.
REQ-020 SHALL assert awready=1 only in W_IDLE; on handshake it SHALL latch awid, awaddr and awlen, then go to W_DATA.
REQ-021 wready SHALL be 1 only in W_DATA; W beats presented before the AW handshake SHALL wait.
REQ-022 On each wvalid&&wready it SHALL write byte lanes i with wstrb[i]=1 at the current word, then increment.
REQ-023 The write burst SHALL end after awlen+1 beats, counted by the slave; wlast SHALL be ignored.
REQ-024 After the final beat the write FSM SHALL enter W_RESP with bvalid=1 and bid = latched awid; on bready it SHALL return to W_IDLE.
REQ-025 Read and write FSMs SHALL operate concurrently and independently.
REQ-026 For a same-cycle RAM write and R_RD read of the same word, the read SHALL return the old data.
REQ-027 rresp and bresp SHALL be 2'b00 (OKAY) except as stated in REQ-032.

Reset
REQ-028 While reset=1 at a clock edge, both FSMs SHALL go to their idle states and all counters SHALL clear to 0.
REQ-029 During reset, arready, awready, wready, rvalid and bvalid SHALL be 0; rdata, rid, bid, rresp, bresp and rlast SHALL be 0.
REQ-030 arready and awready SHALL rise the first cycle after reset deasserts.
REQ-031 Reset mid-burst SHALL abandon the burst with no response; RAM contents SHALL be retained, with no RAM clear.

Configuration
REQ-032 With AXI_SLV_ERR_EN defined, a beat whose addr[31:MEM_AW+2] is nonzero SHALL respond SLVERR (2'b10): reads return rdata=0, and writes are discarded with bresp=2'b10 if any beat of the burst was out of range.
REQ-033 Without AXI_SLV_ERR_EN, the upper address bits SHALL be ignored (addresses alias modulo depth) and all responses SHALL be OKAY.

Verification
REQ-034 Single write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, then read araddr=0x10 -> bresp=0, bid=awid; rdata=0xDEADBEEF, rlast=1, rvalid 2 cycles after AR handshake.
REQ-035 Partial write wstrb=4'b0010, wdata=0x0000AA00 over a word holding 0x11223344 -> read returns 0x1122AA44.
REQ-036 Write burst awlen=3 at 0x100 with data 1,2,3,4, then read arlen=3 -> four beats 1,2,3,4, rlast only on the 4th, rready toggled 1/0 with rdata stable while stalled.
REQ-037 AW and AR in the same cycle to the same word (old value 0x5, new 0x9) -> read returns 0x5; a subsequent read returns 0x9.
REQ-038 Assert reset in W_DATA after beat 2 of 4 -> wready and bvalid go 0, no B issued, awready=1 the next cycle, beats 1-2 remain in RAM.
REQ-039 With AXI_SLV_ERR_EN defined, read araddr=0x0010_0000 at MEM_AW=10 -> rresp=2'b10, rdata=0; without the macro -> aliased word 0 returned, rresp=0.
